// File: rtl/fft_output_ctrl.sv
// -----------------------------------------------------------------------------
// fft_output_ctrl
//
// Streams one 64-point FFT result frame from the result SRAM to a downstream
// ready/valid consumer. Reads are paced so that words already held plus words
// still in flight never exceed a 2-entry skid buffer. This allows one word per
// cycle with out_ready high, and lets the block stall without loss when
// out_ready is low. The SRAM can be walked in natural or bit-reversed address
// order. The order is chosen once per frame. out_index always counts in
// natural bin order.
//
// Ports
//   clk          system clock, rising-edge active
//   n_rst        asynchronous active-low reset
//   output_ena   level request: high streams one frame; low aborts or re-arms
//   bit_rev_en   selects bit-reversed SRAM addressing, latched at frame start
//   sram_rdata   SRAM read data {real[15:0], imag[15:0]}, one cycle after ren
//   out_ready    downstream ready
//   sram_ren     SRAM read request
//   sram_raddr   SRAM read address
//   out_data     streamed result word (buffer head)
//   out_valid    out_data valid (buffer non-empty)
//   out_index    natural-order bin index of out_data
//   output_done  one-cycle pulse after the 64th SRAM word is captured
//   data_sent    one-cycle pulse after the 64th word is accepted downstream
// -----------------------------------------------------------------------------
module fft_output_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        output_ena,
  input  logic        bit_rev_en,
  input  logic [31:0] sram_rdata,
  input  logic        out_ready,
  output logic        sram_ren,
  output logic [5:0]  sram_raddr,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic [5:0]  out_index,
  output logic        output_done,
  output logic        data_sent
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [5:0]  rd_idx_r;
  logic [5:0]  out_idx_r;
  logic        rev_r;
  logic        inflight_r;
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  occ_r;
  logic        done_r;
  logic [31:0] buf_r [2];

  logic        pop_s;
  logic        ren_s;
  logic [2:0]  room_s;
  logic        start_s;
  logic        abort_s;
  logic        flush_s;
  logic        last_rd_s;
  logic        last_pop_s;

  // Mirror a 6-bit index to obtain the bit-reversed SRAM address.
  function automatic logic [5:0] bit_rev6(input logic [5:0] idx);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i] = idx[5-i];
    end
    return r;
  endfunction

  // Handshake, read pacing and frame start/abort decode.
  always_comb begin
    pop_s  = (occ_r != 2'd0) && out_ready;
    // Words held plus the word in flight, less the one leaving this cycle.
    // A pop implies occ_r >= 1, so this cannot underflow.
    room_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (state_r == ST_FETCH) begin
      ren_s = (room_s < 3'd2);
    end else begin
      ren_s = 1'b0;
    end
    start_s    = (state_r == ST_IDLE) && output_ena;
    abort_s    = ((state_r == ST_FETCH) || (state_r == ST_DRAIN)) && !output_ena;
    flush_s    = start_s || abort_s;
    last_rd_s  = ren_s && (rd_idx_r == 6'd63);
    last_pop_s = pop_s && (out_idx_r == 6'd63);
  end

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (output_ena) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!output_ena) begin
          state_nxt_s = ST_IDLE;
        end else if (last_rd_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (!output_ena) begin
          state_nxt_s = ST_IDLE;
        end else if (last_pop_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_HOLD;
      end
      ST_HOLD: begin
        // Stay here until the request is withdrawn, so no second frame can
        // start while output_ena is still held high.
        if (!output_ena) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read index, bin index, buffer occupancy and in-flight tracking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_idx_r   <= 6'd0;
      out_idx_r  <= 6'd0;
      rev_r      <= 1'b0;
      inflight_r <= 1'b0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      occ_r      <= 2'd0;
    end else if (flush_s) begin
      // Start and abort both empty the buffer and drop any read still in
      // flight. Only a start also rewinds the counters and latches the order.
      inflight_r <= 1'b0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      occ_r      <= 2'd0;
      if (start_s) begin
        rd_idx_r  <= 6'd0;
        out_idx_r <= 6'd0;
        rev_r     <= bit_rev_en;
      end else begin
        rd_idx_r  <= rd_idx_r;
        out_idx_r <= out_idx_r;
        rev_r     <= rev_r;
      end
    end else begin
      inflight_r <= ren_s;
      if (ren_s) begin
        rd_idx_r <= rd_idx_r + 6'd1;
      end
      if (inflight_r) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r  <= ~rd_ptr_r;
        out_idx_r <= out_idx_r + 6'd1;
      end
      occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

  // Two-entry skid buffer storage. Data arrives one cycle after the read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_r[0] <= 32'd0;
      buf_r[1] <= 32'd0;
    end else if (!flush_s && inflight_r) begin
      buf_r[wr_ptr_r] <= sram_rdata;
    end
  end

  // output_done pulse. In DRAIN, the only read in flight is the 64th.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DRAIN) && inflight_r && !abort_s;
    end
  end

  assign sram_ren    = ren_s;
  assign sram_raddr  = rev_r ? bit_rev6(rd_idx_r) : rd_idx_r;
  assign out_valid   = (occ_r != 2'd0);
  assign out_data    = buf_r[rd_ptr_r];
  assign out_index   = out_idx_r;
  assign output_done = done_r;
  assign data_sent   = (state_r == ST_DONE);

endmodule

// File: tb/tb_fft_output_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_output_ctrl
//
// Directed bench for fft_output_ctrl. The SRAM model returns {addr, addr} in
// both 16-bit halves one cycle after each read. A negedge monitor checks:
//   - every read address against the expected natural or bit-reversed order;
//   - that a read is only issued when there is room for it;
//   - every accepted word against the expected bin index and data;
//   - that out_data and out_index stay stable while stalled;
//   - pulse counts and cycle positions relative to the start edge E0.
// Stimulus changes 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_fft_output_ctrl;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        output_ena;
  logic        bit_rev_en;
  logic [31:0] sram_rdata = 32'd0;
  logic        out_ready;
  logic        sram_ren;
  logic [5:0]  sram_raddr;
  logic [31:0] out_data;
  logic        out_valid;
  logic [5:0]  out_index;
  logic        output_done;
  logic        data_sent;

  int n_vec  = 0;
  int n_miss = 0;

  int cyc = 0;
  int c0  = 0;
  int rel;
  int rd_cnt, hs_cnt, done_cnt, sent_cnt;
  int done_rel, sent_rel, first_rel, max_out;
  bit mon_en = 1'b0;
  bit rev_q  = 1'b0;
  bit stalled_prev = 1'b0;
  logic [31:0] held_data;
  logic [5:0]  held_idx;
  logic        ren_seen = 1'b0;
  logic [5:0]  addr_seen = 6'd0;

  always #5 tb_clk = ~tb_clk;

  fft_output_ctrl dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .output_ena  (output_ena),
    .bit_rev_en  (bit_rev_en),
    .sram_rdata  (sram_rdata),
    .out_ready   (out_ready),
    .sram_ren    (sram_ren),
    .sram_raddr  (sram_raddr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .output_done (output_done),
    .data_sent   (data_sent)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] rev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  function automatic logic [31:0] word_of(input int k, input bit rev);
    logic [5:0] a;
    logic [5:0] kk;
    kk = k[5:0];
    a  = rev ? rev6(kk) : kk;
    return {10'd0, a, 10'd0, a};
  endfunction

  // SRAM model: data for the read seen in the previous cycle.
  always @(posedge tb_clk) begin
    if (ren_seen) sram_rdata <= {10'd0, addr_seen, 10'd0, addr_seen};
  end

  // Cycle counter, SRAM request capture and output monitor.
  always @(negedge tb_clk) begin
    int pop;
    cyc++;
    ren_seen  = sram_ren;
    addr_seen = sram_raddr;
    if (mon_en) begin
      rel = cyc - c0;
      pop = (out_valid && out_ready) ? 1 : 0;
      if ((rd_cnt - hs_cnt) > max_out) max_out = rd_cnt - hs_cnt;
      if (sram_ren) begin
        check_vec("raddr", 32'(sram_raddr), 32'(rev_q ? rev6(rd_cnt[5:0]) : rd_cnt[5:0]));
        check_vec("ren_room", 32'((rd_cnt - hs_cnt - pop) < 2), 32'd1);
        rd_cnt++;
      end
      if (stalled_prev) begin
        check_vec("hold_valid", 32'(out_valid), 32'd1);
        check_vec("hold_data", out_data, held_data);
        check_vec("hold_index", 32'(out_index), 32'(held_idx));
      end
      if (out_valid && first_rel < 0) first_rel = rel;
      if (out_valid && out_ready) begin
        check_vec("out_index", 32'(out_index), 32'(hs_cnt[5:0]));
        check_vec("out_data", out_data, word_of(hs_cnt, rev_q));
        hs_cnt++;
      end
      stalled_prev = out_valid && !out_ready;
      held_data    = out_data;
      held_idx     = out_index;
      if (output_done) begin done_cnt++; done_rel = rel; end
      if (data_sent)   begin sent_cnt++; sent_rel = rel; end
    end
  end

  // Raise output_ena (called at posedge+1); returns at posedge+1 after E0.
  task automatic start_frame(input bit rev);
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0; sent_cnt = 0;
    done_rel = -1; sent_rel = -1; first_rel = -1; max_out = 0;
    stalled_prev = 1'b0;
    rev_q      = rev;
    bit_rev_en = rev;
    output_ena = 1'b1;
    mon_en     = 1'b1;
    @(negedge tb_clk); #1;
    c0 = cyc + 1;
    @(posedge tb_clk); #1;
    bit_rev_en = ~rev;   // must be ignored: the order was latched at E0
  endtask

  task automatic wait_sent(input int budget);
    int n = 0;
    while (sent_cnt == 0 && n < budget) begin
      @(posedge tb_clk); #1;
      n++;
    end
    check_vec("sent_timeout", 32'(sent_cnt != 0), 32'd1);
  endtask

  task automatic frame_checks(input bit full_rate);
    repeat (2) begin @(posedge tb_clk); #1; end
    check_vec("hs_count", 32'(hs_cnt), 32'd64);
    check_vec("rd_count", 32'(rd_cnt), 32'd64);
    check_vec("done_pulses", 32'(done_cnt), 32'd1);
    check_vec("sent_pulses", 32'(sent_cnt), 32'd1);
    check_vec("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
    if (full_rate) begin
      check_vec("first_valid_rel", 32'(first_rel), 32'd2);
      check_vec("done_rel", 32'(done_rel), 32'd65);
      check_vec("sent_rel", 32'(sent_rel), 32'd66);
    end
  endtask

  task automatic end_frame();
    output_ena = 1'b0;
    repeat (2) begin @(posedge tb_clk); #1; end
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_ren"},   32'(sram_ren), 32'd0);
    check_vec({tag, "_raddr"}, 32'(sram_raddr), 32'd0);
    check_vec({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_vec({tag, "_data"},  out_data, 32'd0);
    check_vec({tag, "_index"}, 32'(out_index), 32'd0);
    check_vec({tag, "_done"},  32'(output_done), 32'd0);
    check_vec({tag, "_sent"},  32'(data_sent), 32'd0);
  endtask

  initial begin
    int n;
    n_rst = 1'b1; output_ena = 1'b0; bit_rev_en = 1'b0; out_ready = 1'b0;
    #2 n_rst = 1'b0;
    #1 check_all_zero("reset");
    @(posedge tb_clk); #1;
    n_rst = 1'b1;
    @(posedge tb_clk); #1;

    // Full rate, natural order, then hold with output_ena high.
    out_ready = 1'b1;
    start_frame(1'b0);
    wait_sent(200);
    frame_checks(1'b1);
    repeat (20) begin @(posedge tb_clk); #1; end
    check_vec("hold_no_reads", 32'(rd_cnt), 32'd64);
    check_vec("hold_no_resend", 32'(sent_cnt), 32'd1);
    check_vec("hold_valid_low", 32'(out_valid), 32'd0);
    output_ena = 1'b0;
    @(posedge tb_clk); #1;

    // Back-pressure: stall 10 cycles at word 5, then toggle out_ready.
    start_frame(1'b0);
    begin
      int stall = 0;
      n = 0;
      while (sent_cnt == 0 && n < 600) begin
        if (hs_cnt >= 5 && stall < 10) begin
          out_ready = 1'b0;
          stall++;
        end else if (hs_cnt >= 5) begin
          out_ready = ~out_ready;
        end else begin
          out_ready = 1'b1;
        end
        @(posedge tb_clk); #1;
        n++;
      end
    end
    check_vec("bp_sent_timeout", 32'(sent_cnt != 0), 32'd1);
    out_ready = 1'b1;
    frame_checks(1'b0);
    check_vec("bp_reached_occ2", 32'(max_out), 32'd2);
    end_frame();

    // Bit-reversed addressing at full rate.
    start_frame(1'b1);
    wait_sent(200);
    frame_checks(1'b1);
    end_frame();

    // Abort after the word-20 handshake, then restart from address 0.
    start_frame(1'b0);
    n = 0;
    while (hs_cnt < 21 && n < 100) begin @(posedge tb_clk); #1; n++; end
    check_vec("abort_reach", 32'(hs_cnt >= 21), 32'd1);
    output_ena = 1'b0;
    @(posedge tb_clk); #1;
    check_vec("abort_valid", 32'(out_valid), 32'd0);
    check_vec("abort_ren", 32'(sram_ren), 32'd0);
    repeat (5) begin @(posedge tb_clk); #1; end
    check_vec("abort_no_done", 32'(done_cnt), 32'd0);
    check_vec("abort_no_sent", 32'(sent_cnt), 32'd0);
    check_vec("abort_idle_valid", 32'(out_valid), 32'd0);
    start_frame(1'b0);
    wait_sent(200);
    frame_checks(1'b1);
    end_frame();

    // Asynchronous reset mid-frame, away from any clock edge.
    start_frame(1'b0);
    repeat (10) begin @(posedge tb_clk); #1; end
    mon_en = 1'b0;
    #2 n_rst = 1'b0;
    #1 check_all_zero("midreset");
    output_ena = 1'b0;
    #10 n_rst = 1'b1;
    repeat (3) begin @(posedge tb_clk); #1; end
    check_vec("post_reset_ren", 32'(sram_ren), 32'd0);
    check_vec("post_reset_valid", 32'(out_valid), 32'd0);
    start_frame(1'b0);
    wait_sent(200);
    frame_checks(1'b1);
    end_frame();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fft_output_ctrl.md
FFT_OUTPUT_CTRL -- requirements
Module: fft_output_ctrl

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning.
  clk  input  1  system clock; all state updates on rising edge.
  n_rst  input  1  reset; active-low, asynchronous.
  output_ena  input  1  level from control unit; high requests streaming of one 64-point result frame.
  bit_rev_en  input  1  high selects bit-reversed SRAM addressing; sampled on frame start.
  sram_rdata  input  32  SRAM read data, [31:16] real, [15:0] imag; valid one cycle after sram_ren.
  out_ready  input  1  downstream ready.
  sram_ren  output  1  SRAM read request.
  sram_raddr  output  6  SRAM read address.
  out_data  output  32  streamed result word.
  out_valid  output  1  out_data valid.
  out_index  output  6  natural-order bin index of out_data.
  output_done  output  1  one-cycle pulse: all 64 words fetched from SRAM.
  data_sent  output  1  one-cycle pulse: all 64 words accepted downstream.
REQ-002 Clock: clk; reset: n_rst, asynchronous, active-low.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DRAIN, DONE, HOLD.
REQ-004 IDLE -> FETCH at the edge sampling output_ena=1 (call it E0); bit_rev_en latched at E0; read index, out_index, buffer cleared.
REQ-005 In FETCH, sram_ren SHALL be high when (occupancy + in-flight - pop_this_cycle) < 2; buffer depth 2.
REQ-006 sram_raddr SHALL equal read index (0..63) or its 6-bit bit reversal when latched bit_rev_en=1; index increments on each ren.
REQ-007 sram_rdata SHALL be captured into the buffer at the edge following the ren cycle.
REQ-008 FETCH -> DRAIN at the edge issuing the 64th read; no ren in DRAIN.
REQ-009 output_done SHALL pulse high for exactly one cycle after the edge capturing the 64th word.
REQ-010 out_valid = buffer non-empty; out_data = buffer head; handshake when out_valid && out_ready.
REQ-011 While out_valid && !out_ready, out_data, out_index SHALL hold stable; no word dropped or duplicated.
REQ-012 out_index SHALL increment (mod 64) on each handshake, starting at 0.
REQ-013 Simultaneous capture and pop SHALL leave occupancy unchanged.
REQ-014 DRAIN -> DONE at the 64th handshake; data_sent high for the single cycle in DONE; DONE -> HOLD.
REQ-015 HOLD -> IDLE when output_ena=0; no restart while output_ena stays high.
REQ-016 output_ena=0 sampled in FETCH or DRAIN SHALL abort: -> IDLE next edge, buffer flushed, late rdata discarded, no output_done/data_sent.
REQ-017 With out_ready held high, throughput SHALL be one word per cycle: out_valid first high after E2, handshakes at E3..E66, output_done high after E65, data_sent high after E66.

Reset
REQ-018 n_rst=0 SHALL immediately force state IDLE, sram_ren=0, sram_raddr=0, out_valid=0, out_data=0, out_index=0, output_done=0, data_sent=0, occupancy=0, read index=0.
REQ-019 Reset mid-frame SHALL discard the frame; the next frame requires output_ena sampled high after release.

Verification
REQ-020 Reset: assert n_rst=0 mid-frame -> all outputs 0 without waiting for clk.
REQ-021 Full rate: SRAM model rdata={addr,addr}, out_ready=1, output_ena=1 -> 64 words, out_data[15:0]=0..63 in order, output_done after E65, data_sent after E66, each one cycle.
REQ-022 Back-pressure: out_ready=0 for 10 cycles at word 5, then toggling -> sram_ren low once occupancy=2, all 64 words exactly once, out_data stable while stalled.
REQ-023 bit_rev_en=1 -> sram_raddr sequence 0,32,16,48,8,...,63; out_index still 0..63.
REQ-024 Abort: output_ena=0 after word 20 handshake -> IDLE next edge, out_valid=0, no pulses; re-raise -> new frame starts at address 0.
REQ-025 Hold: output_ena held high 20 cycles after data_sent -> no sram_ren; drop one cycle, raise -> new frame.
